vt52_command_parser: RTL
========================

// Module: vt52_command_parser
// PURPOSE
//  Consumes the host byte stream (USB-UART out pipe) and interprets a VT52 subset.
//  Drives the char buffer write port, cursor position registers and scroll row (first_row)
//  of the 64x16 text display. Sits upstream of the char generator / cursor position stage.
//  Owns the authoritative copy of cursor and first_row state.
// PARAMETERS
//  COLS_LOG2  6  log2 columns (64)
//  ROWS_LOG2  4  log2 rows (16); char address width = COLS_LOG2+ROWS_LOG2 = 10
//  BLANK      8'h20  fill character for clears/scroll
// PORTS
//  clk                input   1   system clock, all logic on posedge
//  clr                input   1   asynchronous reset, active high
//  in_data            input   8   byte from host
//  in_valid           input   1   in_data valid
//  in_ready           output  1   parser can accept; transfer when in_valid & in_ready
//  new_char           output  8   char to write
//  new_char_address   output  10  physical buffer address {phys_row, col}
//  new_char_wen       output  1   one-cycle write strobe
//  new_cursor_x       output  6   cursor column
//  new_cursor_y       output  4   cursor logical row
//  new_cursor_wen     output  1   one-cycle strobe: cursor x/y valid
//  new_first_row      output  4   physical row shown at top
//  new_first_row_wen  output  1   one-cycle strobe: first_row valid
// BEHAVIOUR
//  Reset: in_ready=1, all strobes 0, cursor (0,0), first_row 0, char/address 0, state IDLE.
//  All outputs registered; byte accepted at edge N -> its strobes visible in cycle N+1.
//  phys_row = (first_row + logical_row) mod 16; address = {phys_row, col}.
//  States: IDLE, ESC, ESC_Y_ROW, ESC_Y_COL, CLEAR.
//  IDLE byte handling (bytes not listed are dropped, no strobes):
//   0x20-0x7E: write at cursor; x+1, saturate at 63 (no autowrap); cursor_wen pulses.
//   0x0D CR: x=0.  0x08 BS: x-1 if x>0.  0x09 TAB: x=min((x|7)+1, 63).
//   0x0A LF: y<15 -> y+1; y==15 -> first_row+1 (wraps mod 16, first_row_wen), then CLEAR
//     logical row 15 cols 0..63. Cursor stays y=15.
//   0x1B: -> ESC.  Cursor-changing bytes pulse cursor_wen even if value unchanged.
//  ESC next byte, then IDLE unless noted: 'A' y-1 (sat 0), 'B' y+1 (sat 15),
//   'C' x+1 (sat 63), 'D' x-1 (sat 0), 'H' home (0,0), 'Y' -> ESC_Y_ROW,
//   'J' CLEAR logical index y*64+x .. 1023, 'K' CLEAR y*64+x .. y*64+63; other: drop.
//  ESC_Y_ROW: row=byte-32, clamp to [0,15] (byte<32 ->0) -> ESC_Y_COL.
//  ESC_Y_COL: col=byte-32, clamp to [0,63]; x,y load together, one cursor_wen -> IDLE.
//  CLEAR: 10-bit logical index counter; one BLANK write per cycle from start to end
//   inclusive (L cells = L consecutive wen cycles, first at N+1). in_ready=0 from N+1
//   through last write cycle; 1 in the cycle after it. No cursor change during clears.
//  in_ready=1 in all other states (1 byte/cycle sustained for non-clear bytes).
//  in_valid with in_ready=0: byte not consumed, must be held by source.
//  clr mid-operation (incl. CLEAR or partial ESC sequence): immediate return to reset
//   values; pending clear abandoned, partial sequence discarded.
// TESTING
//  Reset, send "AB" -> wen at addr 0 'A', addr 1 'B'; cursor (2,0); in_ready stays 1.
//  Cursor at x=63, send 'Z','Q' -> both written to addr 63; cursor x stays 63.
//  ESC 'Y' 0x25 0x2A -> single cursor_wen, (x=10,y=5); ESC Y 0x7F 0x7F -> (63,15).
//  Cursor y=15, first_row=0, LF -> first_row_wen with 1, then 64 writes of 0x20 to
//   addr 0..63 (phys row 0), in_ready low exactly those 64 cycles.
//  Cursor (60,2), ESC 'K' -> 4 blank writes addr 188..191; ESC 'J' from (0,0) -> 1024 writes.
//  Assert clr during ESC 'J' clear at write 100 -> wen stops, in_ready=1, cursor (0,0).

Source files
------------

// File: rtl/vt52_command_parser_if.sv
// Byte stream from the host plus the display-update strobes produced by the VT52 parser.
// The master side is the host/display environment; the parser connects on the slave side.
interface vt52_command_parser_if #(
   parameter int COLS_LOG2 = 6,
   parameter int ROWS_LOG2 = 4
);
   logic [7:0]                     in_data;
   logic                           in_valid;
   logic                           in_ready;
   logic [7:0]                     new_char;
   logic [COLS_LOG2+ROWS_LOG2-1:0] new_char_address;
   logic                           new_char_wen;
   logic [COLS_LOG2-1:0]           new_cursor_x;
   logic [ROWS_LOG2-1:0]           new_cursor_y;
   logic                           new_cursor_wen;
   logic [ROWS_LOG2-1:0]           new_first_row;
   logic                           new_first_row_wen;

   modport master (
      output in_data, in_valid,
      input  in_ready, new_char, new_char_address, new_char_wen,
      input  new_cursor_x, new_cursor_y, new_cursor_wen,
      input  new_first_row, new_first_row_wen
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, new_char, new_char_address, new_char_wen,
      output new_cursor_x, new_cursor_y, new_cursor_wen,
      output new_first_row, new_first_row_wen
   );
endinterface

// File: rtl/vt52_command_parser.sv
// VT52-subset interpreter: turns host bytes into char-buffer writes, cursor moves and
// scroll updates for a circular text buffer; owns the cursor and first_row state.
module vt52_command_parser #(
   parameter int         COLS_LOG2 = 6,
   parameter int         ROWS_LOG2 = 4,
   parameter logic [7:0] BLANK     = 8'h20
) (
   input logic                  clk,
   input logic                  clr,
   vt52_command_parser_if.slave bus
);
   localparam int AW      = COLS_LOG2 + ROWS_LOG2;
   localparam int MAX_COL = (1 << COLS_LOG2) - 1;
   localparam int MAX_ROW = (1 << ROWS_LOG2) - 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ESC     = 3'd1;
   localparam logic [2:0] S_Y_ROW   = 3'd2;
   localparam logic [2:0] S_Y_COL   = 3'd3;
   localparam logic [2:0] S_CLEAR   = 3'd4;

   localparam logic [COLS_LOG2-1:0] X_ONE = COLS_LOG2'(1);
   localparam logic [ROWS_LOG2-1:0] Y_ONE = ROWS_LOG2'(1);
   localparam logic [AW-1:0]        A_ONE = AW'(1);

   logic [2:0]           state;
   logic [COLS_LOG2-1:0] cursor_x;
   logic [ROWS_LOG2-1:0] cursor_y;
   logic [ROWS_LOG2-1:0] first_row;
   logic [ROWS_LOG2-1:0] pend_row;
   logic [AW-1:0]        clr_idx;
   logic [AW-1:0]        clr_end;
   logic                 ready;
   logic [7:0]           char_q;
   logic [AW-1:0]        addr_q;
   logic                 char_wen;
   logic                 cursor_wen;
   logic                 fr_wen;

   logic                 accept;
   logic [7:0]           b;

   assign accept = bus.in_valid & ready;
   assign b      = bus.in_data;

   assign bus.in_ready          = ready;
   assign bus.new_char          = char_q;
   assign bus.new_char_address  = addr_q;
   assign bus.new_char_wen      = char_wen;
   assign bus.new_cursor_x      = cursor_x;
   assign bus.new_cursor_y      = cursor_y;
   assign bus.new_cursor_wen    = cursor_wen;
   assign bus.new_first_row     = first_row;
   assign bus.new_first_row_wen = fr_wen;

   // ESC Y coordinates are biased by 32; out-of-range values pin to the screen edge.
   function automatic int clamp_offset(input logic [7:0] v, input int hi);
      int d;
      d = int'(v) - 32;
      if (d < 0) return 0;
      if (d > hi) return hi;
      return d;
   endfunction

   function automatic logic [COLS_LOG2-1:0] inc_x(input logic [COLS_LOG2-1:0] x);
      return (x == '1) ? x : x + X_ONE;
   endfunction

   function automatic logic [COLS_LOG2-1:0] dec_x(input logic [COLS_LOG2-1:0] x);
      return (x == '0) ? x : x - X_ONE;
   endfunction

   function automatic logic [ROWS_LOG2-1:0] inc_y(input logic [ROWS_LOG2-1:0] y);
      return (y == '1) ? y : y + Y_ONE;
   endfunction

   function automatic logic [ROWS_LOG2-1:0] dec_y(input logic [ROWS_LOG2-1:0] y);
      return (y == '0) ? y : y - Y_ONE;
   endfunction

   function automatic logic [COLS_LOG2-1:0] tab_stop(input logic [COLS_LOG2-1:0] x);
      logic [COLS_LOG2:0] t;
      t = {1'b0, x | COLS_LOG2'(7)} + (COLS_LOG2+1)'(1);
      return t[COLS_LOG2] ? '1 : t[COLS_LOG2-1:0];
   endfunction

   // Logical rows are relative to first_row; the buffer row index wraps.
   function automatic logic [AW-1:0] phys_addr(input logic [ROWS_LOG2-1:0] fr,
                                               input logic [AW-1:0]        lin);
      logic [ROWS_LOG2-1:0] row;
      row = fr + lin[AW-1:COLS_LOG2];
      return {row, lin[COLS_LOG2-1:0]};
   endfunction

   logic                 clear_go;
   logic                 lf_scroll;
   logic [AW-1:0]        clear_lo;
   logic [AW-1:0]        clear_hi;
   logic [ROWS_LOG2-1:0] clear_fr;

   // Clear start: the first BLANK write is issued on the same edge that accepts the byte.
   always_comb begin
      lf_scroll = accept && (state == S_IDLE) && (b == 8'h0A) && (cursor_y == '1);
      clear_go  = 1'b0;
      clear_lo  = {cursor_y, cursor_x};
      clear_hi  = {cursor_y, {COLS_LOG2{1'b1}}};
      clear_fr  = first_row;
      if (lf_scroll) begin
         clear_go = 1'b1;
         clear_lo = {cursor_y, {COLS_LOG2{1'b0}}};
         clear_fr = first_row + Y_ONE;
      end else if (accept && (state == S_ESC) && (b == "J")) begin
         clear_go = 1'b1;
         clear_hi = '1;
      end else if (accept && (state == S_ESC) && (b == "K")) begin
         clear_go = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state      <= S_IDLE;
         cursor_x   <= '0;
         cursor_y   <= '0;
         first_row  <= '0;
         pend_row   <= '0;
         clr_idx    <= '0;
         clr_end    <= '0;
         ready      <= 1'b1;
         char_q     <= '0;
         addr_q     <= '0;
         char_wen   <= 1'b0;
         cursor_wen <= 1'b0;
         fr_wen     <= 1'b0;
      end else begin
         char_wen   <= 1'b0;
         cursor_wen <= 1'b0;
         fr_wen     <= 1'b0;
         if (state == S_CLEAR) begin
            if (clr_idx == clr_end) begin
               state <= S_IDLE;
               ready <= 1'b1;
            end else begin
               clr_idx  <= clr_idx + A_ONE;
               char_wen <= 1'b1;
               char_q   <= BLANK;
               addr_q   <= phys_addr(first_row, clr_idx + A_ONE);
            end
         end else if (accept) begin
            case (state)
               S_IDLE: begin
                  if (b >= 8'h20 && b <= 8'h7E) begin
                     char_wen   <= 1'b1;
                     char_q     <= b;
                     addr_q     <= phys_addr(first_row, {cursor_y, cursor_x});
                     cursor_x   <= inc_x(cursor_x);
                     cursor_wen <= 1'b1;
                  end else begin
                     case (b)
                        8'h0D: begin
                           cursor_x   <= '0;
                           cursor_wen <= 1'b1;
                        end
                        8'h08: begin
                           cursor_x   <= dec_x(cursor_x);
                           cursor_wen <= 1'b1;
                        end
                        8'h09: begin
                           cursor_x   <= tab_stop(cursor_x);
                           cursor_wen <= 1'b1;
                        end
                        8'h0A: begin
                           cursor_wen <= 1'b1;
                           if (cursor_y != '1) begin
                              cursor_y <= cursor_y + Y_ONE;
                           end else begin
                              first_row <= clear_fr;
                              fr_wen    <= 1'b1;
                           end
                        end
                        8'h1B:   state <= S_ESC;
                        default: ;
                     endcase
                  end
               end
               S_ESC: begin
                  state <= S_IDLE;
                  case (b)
                     "A": begin
                        cursor_y   <= dec_y(cursor_y);
                        cursor_wen <= 1'b1;
                     end
                     "B": begin
                        cursor_y   <= inc_y(cursor_y);
                        cursor_wen <= 1'b1;
                     end
                     "C": begin
                        cursor_x   <= inc_x(cursor_x);
                        cursor_wen <= 1'b1;
                     end
                     "D": begin
                        cursor_x   <= dec_x(cursor_x);
                        cursor_wen <= 1'b1;
                     end
                     "H": begin
                        cursor_x   <= '0;
                        cursor_y   <= '0;
                        cursor_wen <= 1'b1;
                     end
                     "Y":     state <= S_Y_ROW;
                     default: ;
                  endcase
               end
               S_Y_ROW: begin
                  pend_row <= ROWS_LOG2'(clamp_offset(b, MAX_ROW));
                  state    <= S_Y_COL;
               end
               S_Y_COL: begin
                  cursor_y   <= pend_row;
                  cursor_x   <= COLS_LOG2'(clamp_offset(b, MAX_COL));
                  cursor_wen <= 1'b1;
                  state      <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
            if (clear_go) begin
               state    <= S_CLEAR;
               ready    <= 1'b0;
               clr_idx  <= clear_lo;
               clr_end  <= clear_hi;
               char_wen <= 1'b1;
               char_q   <= BLANK;
               addr_q   <= phys_addr(clear_fr, clear_lo);
            end
         end
      end
   end
endmodule
